// File: rtl/soc_system_pio_out.sv
// Avalon-MM output PIO with set/clear aliases and an auto-clearing pulse
// generator: masked bits written high drop back low after PULSE_LEN cycles.
module soc_system_pio_out #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          PW          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_LEN      = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [PW-1:0]    len_q, len_d;
    logic [PW-1:0]    count_q, count_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             trigger;
    logic             expire;

    always_comb begin
        wr_en   = chipselect & ~write_n;
        wr_data = writedata[WIDTH-1:0];
        trigger = wr_en
                  && (address == ADDR_DATA || address == ADDR_OUTSET)
                  && ((wr_data & mask_q) != '0)
                  && (len_q != '0);
        // A retrigger on the last pulse cycle keeps the bits high instead of clearing them.
        expire  = (count_q == PW'(1)) && !trigger;

        data_d = expire ? (data_q & ~mask_q) : data_q;
        mask_d = mask_q;
        len_d  = len_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wr_data;
                ADDR_MASK:     mask_d = wr_data;
                ADDR_LEN:      len_d  = writedata[PW-1:0];
                ADDR_OUTSET:   data_d = data_d | wr_data;
                ADDR_OUTCLEAR: data_d = data_d & ~wr_data;
                default:       ;
            endcase
        end

        if (trigger) begin
            count_d = len_q;
        end else if (count_q != '0) begin
            count_d = count_q - PW'(1);
        end else begin
            count_d = '0;
        end

        case (address)
            ADDR_DATA:   readdata_d = 32'(data_q);
            ADDR_MASK:   readdata_d = 32'(mask_q);
            ADDR_LEN:    readdata_d = 32'(len_q);
            ADDR_STATUS: readdata_d = {16'(count_q), 15'b0, (count_q != '0)};
            default:     readdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE[WIDTH-1:0];
            mask_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            readdata_q <= 32'h0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q;

endmodule
